// File: rtl/xgmac_link_ctrl_if.sv
// ---------------------------------------------------------------------------
// xgmac_link_ctrl_if
//   Signal bundle between the 10G link sequencer and the PHY / MAC it controls.
//   master : the sequencer (observes PHY status, drives PHY reset and MAC enables)
//   slave  : the PHY/MAC side (drives status, observes reset/enables/link state)
//   Signals:
//     restart        one-cycle request to restart the bring-up sequence
//     resetdone      PHY transceiver reset complete
//     core_status    PHY status, bit0 = PCS block lock
//     signal_detect  optics signal present
//     tx_fault       optics transmit fault
//     xphy_reset     reset to the PHY reset/interface logic
//     mac_tx_enable  MAC transmit enable
//     mac_rx_enable  MAC receive enable
//     link_up        link declared up
//     link_change    one-cycle pulse on every link_up edge
//     link_fault     retry budget exhausted
//     retry_cnt      retries since last link-up
//     ctrl_state     sequencer state encoding (debug)
// ---------------------------------------------------------------------------
interface xgmac_link_ctrl_if;
  logic       restart;
  logic       resetdone;
  logic [7:0] core_status;
  logic       signal_detect;
  logic       tx_fault;
  logic       xphy_reset;
  logic       mac_tx_enable;
  logic       mac_rx_enable;
  logic       link_up;
  logic       link_change;
  logic       link_fault;
  logic [2:0] retry_cnt;
  logic [2:0] ctrl_state;

  modport master (
    input  restart, resetdone, core_status, signal_detect, tx_fault,
    output xphy_reset, mac_tx_enable, mac_rx_enable, link_up, link_change,
           link_fault, retry_cnt, ctrl_state
  );

  modport slave (
    output restart, resetdone, core_status, signal_detect, tx_fault,
    input  xphy_reset, mac_tx_enable, mac_rx_enable, link_up, link_change,
           link_fault, retry_cnt, ctrl_state
  );
endinterface

// File: rtl/xgmac_link_ctrl.sv
// ---------------------------------------------------------------------------
// xgmac_link_ctrl
//   Link bring-up / recovery sequencer for the 10G MAC+PHY path (clk156).
//   Pulses the PHY reset, waits for transceiver reset completion, qualifies
//   PCS block lock over a stability window, then enables the MAC. Loss of
//   lock or faults restart the sequence with a bounded retry budget.
//   Ports:
//     clk156  core clock, 156.25 MHz
//     reset   synchronous, active-high
//     bus     xgmac_link_ctrl_if.master (PHY status in, PHY reset / MAC
//             enables / link status out)
// ---------------------------------------------------------------------------
module xgmac_link_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int DONE_TIMEOUT = 65535,
  parameter int LOCK_CYCLES  = 1024,
  parameter int LOSS_CYCLES  = 256,
  parameter int MAX_RETRY    = 7,
  parameter int CNT_W        = 20
) (
  input  logic                clk156,
  input  logic                reset,
  xgmac_link_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    ST_RST_PHY   = 3'd0,
    ST_WAIT_DONE = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_LINK_UP   = 3'd3,
    ST_LOSS      = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_CYCLES - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx_s;
  logic [CNT_W-1:0] tmo_q, tmo_d, tmo_nx_s;
  logic [2:0]       retry_q, retry_d;
  logic             link_change_q, link_change_d;
  logic             lock_ok_s;
  logic             clear_s;
  logic             unused_s;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // link_up is asserted in LINK_UP and while riding out a short LOSS.
  function automatic logic link_up_of(input state_e s);
    return (s == ST_LINK_UP) || (s == ST_LOSS);
  endfunction

  assign lock_ok_s = bus.core_status[0] & bus.signal_detect & ~bus.tx_fault;
  assign unused_s  = ^bus.core_status[7:1];

  // Next-state, counter and retry-budget logic.
  always_comb begin
    state_d  = state_q;
    cnt_nx_s = cnt_q;
    tmo_nx_s = tmo_q;
    retry_d  = retry_q;
    if (bus.restart) begin
      state_d = ST_RST_PHY;
      retry_d = 3'd0;
    end else if (!bus.resetdone &&
                 ((state_q == ST_WAIT_LOCK) || (state_q == ST_LINK_UP) ||
                  (state_q == ST_LOSS))) begin
      state_d = ST_RST_PHY;
    end else begin
      case (state_q)
        ST_RST_PHY: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_DONE;
          end else begin
            cnt_nx_s = sat_inc(cnt_q);
          end
        end
        ST_WAIT_DONE: begin
          if (bus.resetdone) begin
            state_d = ST_WAIT_LOCK;
          end else if (tmo_q == TMO_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              retry_d = retry_q + 3'd1;
              state_d = ST_RST_PHY;
            end
          end else begin
            tmo_nx_s = sat_inc(tmo_q);
          end
        end
        ST_WAIT_LOCK: begin
          // Link-up wins over a timeout landing in the same cycle.
          if (lock_ok_s && (cnt_q == LOCK_LAST)) begin
            state_d = ST_LINK_UP;
            retry_d = 3'd0;
          end else if (tmo_q == TMO_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              retry_d = retry_q + 3'd1;
              state_d = ST_RST_PHY;
            end
          end else begin
            cnt_nx_s = lock_ok_s ? sat_inc(cnt_q) : CNT_ZERO;
            tmo_nx_s = sat_inc(tmo_q);
          end
        end
        ST_LINK_UP: begin
          if (!lock_ok_s) begin
            state_d = ST_LOSS;
          end else begin
            state_d = ST_LINK_UP;
          end
        end
        ST_LOSS: begin
          if (lock_ok_s) begin
            state_d = ST_LINK_UP;
            retry_d = 3'd0;
          end else if (cnt_q == LOSS_LAST) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            cnt_nx_s = sat_inc(cnt_q);
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RST_PHY;
        end
      endcase
    end
    // Any state change (or restart, which may stay in RST_PHY) restarts both counters.
    clear_s       = bus.restart || (state_d != state_q);
    cnt_d         = clear_s ? CNT_ZERO : cnt_nx_s;
    tmo_d         = clear_s ? CNT_ZERO : tmo_nx_s;
    link_change_d = link_up_of(state_d) != link_up_of(state_q);
  end

  // State, counter and link_change registers.
  always_ff @(posedge clk156) begin
    if (reset) begin
      state_q       <= ST_RST_PHY;
      cnt_q         <= CNT_ZERO;
      tmo_q         <= CNT_ZERO;
      retry_q       <= 3'd0;
      link_change_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      retry_q       <= retry_d;
      link_change_q <= link_change_d;
    end
  end

  assign bus.xphy_reset    = (state_q == ST_RST_PHY);
  assign bus.mac_tx_enable = link_up_of(state_q);
  assign bus.link_up       = link_up_of(state_q);
  assign bus.mac_rx_enable = (state_q == ST_LINK_UP);
  assign bus.link_fault    = (state_q == ST_FAULT);
  assign bus.link_change   = link_change_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.ctrl_state    = state_q;

endmodule
